count_bin_ctrl: RTL
===================

Name: count_bin_ctrl

Overview:
Hardware sequencer for the binary-count display path. It replaces the software counting loop behind the switch/LED/seven-segment PIOs. It synchronises the slider switches and a clear key, generates a selectable-rate count tick, and runs an 8-bit up/down counter. The count drives LEDR[7:0] and a packed active-high seven-segment word in the same hex5_hex4 layout (HEX4 = bits 6:0, HEX5 = bits 14:8), which the board top inverts for the displays.

Parameters:
BASE_DIV, 50000000, clock cycles per tick at rate 0 (1 Hz at 50 MHz); simulation uses 16
CNT_W, 8, counter width; fixed at 8 for the two-digit hex display

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous active-low reset
SW  input  4  raw switches: [0] enable, [1] direction (1 = down), [3:2] rate select
key_clear_n  input  1  raw active-low clear pushbutton
LEDR  output  8  current count, binary
hex5_hex4  output  16  active-high segments: [6:0] low nibble, [14:8] high nibble, [7] and [15:15] = 0
tick  output  1  one-cycle pulse on each counter update (debug/LED use)

Behaviour:
- Reset state: count 0, state IDLE, prescaler 0, synchronisers 0, clear edge-detect history 1. Outputs at reset: LEDR 0x00, hex5_hex4 0x3F3F, tick 0.
- Synchronisers: SW and key_clear_n each pass through a 2-flop synchroniser. A raw change is visible internally 2 cycles later.
- Clear: a falling edge on the synchronised key_clear_n produces a one-cycle clr pulse.
- Rate: rate = SW_sync[3:2]. Tick period P = BASE_DIV >> rate, giving 1, 2, 4 or 8 Hz.
- Prescaler: counts 0..P-1 while in RUN. The tick pulse asserts in the cycle the prescaler equals P-1, and the prescaler then wraps to 0.
- State IDLE: prescaler held at 0; count held.
  - IDLE -> RUN when SW_sync[0] = 1.
- State RUN: prescaler runs; count updates on each tick.
  - RUN -> IDLE when SW_sync[0] = 0. The prescaler is zeroed, and no tick fires in the transition cycle.
- Re-entering RUN: the first tick occurs exactly P cycles after entry.
- Rate change: if SW_sync[3:2] differs from its previous-cycle value, the prescaler is zeroed and no tick fires that cycle.
- Count update on tick:
  - up: count + 1 modulo 256, so 0xFF wraps to 0x00.
  - down: count - 1 modulo 256, so 0x00 wraps to 0xFF.
  - Direction is sampled in the tick cycle; a direction change takes effect at the next tick.
- Clear priority: clr sets count = 0 and zeroes the prescaler in any state. If clr coincides with a tick, clr wins: count = 0 and the tick output is suppressed. Clear does not change the state.
- LEDR: driven directly from the count register, so it changes in the cycle after the tick or clear edge.
- hex5_hex4: registered decode of the count, one cycle behind LEDR. Digits use standard 0-F glyphs, segment order g..a = bits 6..0 (0 -> 0x3F, 1 -> 0x06, A -> 0x77, F -> 0x71).
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Counting restarts from IDLE after release.

Decomposition:
- Shared package count_bin_pkg holds:
  - state enum: IDLE, RUN
  - SW bit-index constants: EN = 0, DIR = 1, RATE_LO = 2, RATE_HI = 3
  - default BASE_DIV
  - the 16-entry seven-segment glyph constant table
- One sub-module, hex7seg: combinational 4-bit to 7-bit decoder, instantiated twice.

Test Plan (all scenarios use BASE_DIV = 16):
- Reset release with SW = 0 -> LEDR 0x00 and hex5_hex4 0x3F3F held for 100 cycles; tick never asserts.
- SW = 0001 (up, rate 0) -> first tick 16 cycles after RUN entry, then every 16 cycles; LEDR 1, 2, 3; after 3 ticks hex5_hex4 = 0x3F4F.
- Count preloaded to 0xFE via ticks, up -> next ticks give 0xFF then 0x00; hex5_hex4 = 0x7171 then 0x3F3F. Switch to down (SW = 0011) -> next tick gives 0xFF.
- SW[3:2] changed from 00 to 11 mid-period -> prescaler restarts; ticks every 2 cycles starting 2 cycles after the synchronised change.
- key_clear_n falling edge placed so clr lands on a tick cycle -> LEDR 0x00, tick stays 0, state remains RUN, next tick P cycles later gives 0x01.
- reset_n asserted mid-RUN at count 0x5A -> LEDR 0x00 and state IDLE immediately; after release with SW[0] = 1, the first tick comes 16 cycles after RUN entry.

Source files
------------

// File: rtl/count_bin_pkg.sv
// Shared types and constants for the binary-count display sequencer.
// Holds the FSM state type, switch bit indices and the segment glyph table.
package count_bin_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int EN      = 0;
    localparam int DIR     = 1;
    localparam int RATE_LO = 2;
    localparam int RATE_HI = 3;

    localparam int DEF_BASE_DIV = 50000000;

    // Active-high glyphs, bit order g..a; index 15 is listed first.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to active-high seven-segment decoder.
// Segment order g..a maps to bits 6..0.
module hex7seg
    import count_bin_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[digit];

endmodule

// File: rtl/count_bin_ctrl.sv
// Binary-count display sequencer: switch/key sync, rate tick, 8-bit counter.
// Drives LEDR with the count and a registered packed two-digit segment word.
module count_bin_ctrl
    import count_bin_pkg::*;
#(
    parameter int BASE_DIV = DEF_BASE_DIV,
    parameter int CNT_W    = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic [3:0]       SW,
    input  logic             key_clear_n,
    output logic [CNT_W-1:0] LEDR,
    output logic [15:0]      hex5_hex4,
    output logic             tick
);

    localparam int PW = $clog2(BASE_DIV + 1);

    logic [3:0]       sw_s1;
    logic [3:0]       sw_s2;
    logic             key_s1;
    logic             key_s2;
    logic             key_prev;
    logic [1:0]       rate;
    logic [1:0]       rate_prev;
    logic             en;
    logic             dir;
    logic             clr;
    logic             rate_chg;
    logic             tick_raw;
    logic [PW-1:0]    period;
    logic [PW-1:0]    presc;
    logic [PW-1:0]    presc_nx;
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nx;
    logic [6:0]       seg_lo;
    logic [6:0]       seg_hi;
    logic [15:0]      hex_q;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1     <= '0;
            sw_s2     <= '0;
            key_s1    <= 1'b0;
            key_s2    <= 1'b0;
            key_prev  <= 1'b1;
            rate_prev <= '0;
        end else begin
            sw_s1     <= SW;
            sw_s2     <= sw_s1;
            key_s1    <= key_clear_n;
            key_s2    <= key_s1;
            key_prev  <= key_s2;
            rate_prev <= rate;
        end
    end

    assign rate     = sw_s2[RATE_HI:RATE_LO];
    assign en       = sw_s2[EN];
    assign dir      = sw_s2[DIR];
    assign clr      = key_prev & ~key_s2;
    assign rate_chg = (rate != rate_prev);
    assign period   = PW'(BASE_DIV >> rate);

    always_comb begin
        state_nx = state;
        presc_nx = '0;
        count_nx = count;
        tick_raw = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) state_nx = RUN;
            end
            RUN: begin
                if (!en) begin
                    state_nx = IDLE;
                end else if (!rate_chg) begin
                    if (presc == period - PW'(1)) tick_raw = 1'b1;
                    else presc_nx = presc + PW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        if (tick_raw) begin
            count_nx = dir ? count - CNT_W'(1)
                           : count + CNT_W'(1);
        end
        // Clear outranks a coincident tick and restarts the period.
        if (clr) begin
            presc_nx = '0;
            count_nx = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            presc <= '0;
            count <= '0;
            hex_q <= 16'h3F3F;
        end else begin
            state <= state_nx;
            presc <= presc_nx;
            count <= count_nx;
            hex_q <= {1'b0, seg_hi, 1'b0, seg_lo};
        end
    end

    hex7seg u_seg_lo (
        .digit (count[3:0]),
        .seg   (seg_lo)
    );

    hex7seg u_seg_hi (
        .digit (count[7:4]),
        .seg   (seg_hi)
    );

    assign tick      = tick_raw & ~clr;
    assign LEDR      = count;
    assign hex5_hex4 = hex_q;

endmodule
